// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t  : receiver FSM state encoding
//   PARITY_*    : values of the parity_type input
//   STOP_*      : values of the stop_bits input
//   maj3        : 3-input majority used by the bit voter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_1      = 1'b0;
  localparam logic STOP_2      = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: 2-flop synchroniser, free-running
// oversample counter (restartable on start-bit detection) and a 3-sample
// majority voter around the bit centre.
// Ports:
//   clk_16bd   in  oversampling clock
//   rst        in  synchronous active-high reset
//   rx         in  asynchronous serial line
//   restart    in  force the sample counter to 0 on the next edge
//   rx_s       out synchronised line
//   bit_value  out majority of rx_s at counts MID-1, MID, MID+1
//   bit_decide out high while count == MID+1 (bit_value valid)
//   bit_end    out high while count == OVERSAMPLE-1
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_s,
  output logic bit_value,
  output logic bit_decide,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_P1 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

  logic          sync1;
  logic [CW-1:0] cnt;
  logic          samp_a;
  logic          samp_b;

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      cnt    <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
      if (restart || cnt == LAST) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
      if (cnt == MID_M1) samp_a <= rx_s;
      if (cnt == MID)    samp_b <= rx_s;
    end
  end

  // Third vote is the live rx_s at MID+1, so the decision is available
  // in the same cycle without an extra register stage.
  assign bit_value  = maj3(samp_a, samp_b, rx_s);
  assign bit_decide = (cnt == MID_P1);
  assign bit_end    = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Run-time configurable UART receiver with valid/ready output register.
// Frame: start, 1..DATA_W data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. Each frame is delivered with parity/frame/break flags.
// Ports:
//   clk_16bd, rst                    clock, synchronous active-high reset
//   rx                               asynchronous serial input (idle high)
//   parity_en, parity_type,
//   stop_bits, frame_length          frame format, latched at start detect
//   rx_data, rx_valid, rx_ready      output holding register handshake
//   parity_err, frame_err, break_det per-frame flags, qualified by rx_valid
//   overrun, clr_overrun             sticky lost-frame flag and its clear
//   busy                             receiver not idle
// Handshake: rx_data and the flags are stable while rx_valid is high; a
// transfer happens on any edge where rx_valid && rx_ready. A new frame may
// load in the same cycle as a transfer; otherwise a frame finishing while
// rx_valid is high is dropped and overrun is set.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int OVERSAMPLE = 16,
  parameter int FL_W       = $clog2(DATA_W + 1)
) (
  input  logic              clk_16bd,
  input  logic              rst,
  input  logic              rx,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic              stop_bits,
  input  logic [FL_W-1:0]   frame_length,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              busy
);

  localparam logic [FL_W-1:0] LEN_MAX = FL_W'(DATA_W);

  rx_state_t state, state_next;

  logic rx_s, bit_value, bit_decide, bit_end;
  logic restart;

  // Frame configuration captured at start detection
  logic            par_en_q;
  logic            par_type_q;
  logic            stop2_q;
  logic [FL_W-1:0] len_q;
  logic [FL_W-1:0] len_eff;

  // Per-frame accumulators
  logic [FL_W-1:0]   idx;
  logic [DATA_W-1:0] data_q;
  logic              perr_q;
  logic              ferr_q;
  logic              zero_q;     // every bit seen so far (break window) was 0
  logic              stop_idx;   // 0 = first stop bit, 1 = second

  logic frame_done;
  logic ferr_final;
  logic brk_final;
  logic load;
  logic accept;

  assign restart = (state == IDLE) && !rx_s;
  assign len_eff = (frame_length == '0 || frame_length > LEN_MAX) ? LEN_MAX : frame_length;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk_16bd   (clk_16bd),
    .rst        (rst),
    .rx         (rx),
    .restart    (restart),
    .rx_s       (rx_s),
    .bit_value  (bit_value),
    .bit_decide (bit_decide),
    .bit_end    (bit_end)
  );

  // FSM state register
  always_ff @(posedge clk_16bd) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; frame_done marks the final stop-bit decision
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START: begin
        if (bit_decide && bit_value) state_next = IDLE;
        else if (bit_end)            state_next = DATA;
      end
      DATA:      if (bit_end && idx == len_q - 1'b1) state_next = par_en_q ? PARITY : STOP;
      PARITY:    if (bit_end) state_next = STOP;
      STOP: begin
        if (bit_decide && stop_idx == stop2_q) begin
          frame_done = 1'b1;
          // A low final stop bit means the line may still be in break;
          // wait for it to go high so the break is not seen as a new start.
          state_next = bit_value ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The final stop bit is folded in combinationally so the holding
  // register can load on the edge right after the decision.
  assign ferr_final = ferr_q | ~bit_value;
  assign brk_final  = zero_q & (stop_idx ? 1'b1 : ~bit_value);

  // Frame datapath
  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      stop2_q    <= STOP_1;
      len_q      <= LEN_MAX;
      idx        <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b1;
      stop_idx   <= 1'b0;
    end else if (restart) begin
      par_en_q   <= parity_en;
      par_type_q <= parity_type;
      stop2_q    <= stop_bits;
      len_q      <= len_eff;
      idx        <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b1;
      stop_idx   <= 1'b0;
    end else begin
      case (state)
        DATA: begin
          if (bit_decide) begin
            for (int i = 0; i < DATA_W; i++) begin
              if (idx == FL_W'(i)) data_q[i] <= bit_value;
            end
            if (bit_value) zero_q <= 1'b0;
          end
          if (bit_end) idx <= idx + 1'b1;
        end
        PARITY: begin
          if (bit_decide) begin
            perr_q <= ((^data_q) ^ bit_value) != par_type_q;
            if (bit_value) zero_q <= 1'b0;
          end
        end
        STOP: begin
          if (bit_decide) begin
            if (!bit_value)             ferr_q <= 1'b1;
            if (!stop_idx && bit_value) zero_q <= 1'b0;
          end
          if (bit_end) stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output holding register
  assign accept = rx_valid && rx_ready;
  assign load   = frame_done && (!rx_valid || rx_ready);

  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_data    <= data_q;
        rx_valid   <= 1'b1;
        parity_err <= perr_q;
        frame_err  <= ferr_final;
        break_det  <= brk_final;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      if (frame_done && !load) overrun <= 1'b1;
      else if (clr_overrun)    overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: frames are generated tick by tick
// on rx, expected {rx_data, parity_err, frame_err, break_det} words are
// queued when a frame is driven and compared when the DUT hands them over.
module tb_uart_rx_param;

  localparam int DATA_W = 9;
  localparam int OS     = 16;
  localparam int FL_W   = 4;
  localparam int EW     = DATA_W + 3;

  // Clock / reset
  logic clk_16bd = 1'b0;
  logic rst;
  always #5 clk_16bd = ~clk_16bd;

  logic              rx;
  logic              parity_en, parity_type, stop_bits;
  logic [FL_W-1:0]   frame_length;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ready;
  logic              parity_err, frame_err, break_det;
  logic              overrun, clr_overrun, busy;

  uart_rx_param #(.DATA_W(DATA_W), .OVERSAMPLE(OS)) dut (
    .clk_16bd     (clk_16bd),
    .rst          (rst),
    .rx           (rx),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .frame_length (frame_length),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun),
    .busy         (busy)
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk_16bd) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_16bd);
      #1;
    end
  endtask

  task automatic set_cfg(input logic pen, input logic ptype, input logic stop2,
                         input logic [FL_W-1:0] flen);
    parity_en    = pen;
    parity_type  = ptype;
    stop_bits    = stop2;
    frame_length = flen;
  endtask

  // Drives one frame plus one idle bit time. spike >= 0 inverts rx for
  // that single tick (tick 0 is the first tick of the start bit).
  task automatic send_frame(input logic [DATA_W-1:0] data, input int nbits,
                            input logic pen, input logic ptype, input logic stop2,
                            input logic [FL_W-1:0] flen, input logic flip_par,
                            input logic push, input int spike);
    logic [15:0]       fb;
    logic [DATA_W-1:0] d;
    int                nb;
    set_cfg(pen, ptype, stop2, flen);
    for (int i = 0; i < DATA_W; i++) d[i] = (i < nbits) ? data[i] : 1'b0;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fb[1+i] = d[i];
    nb = 1 + nbits;
    if (pen) begin
      fb[nb] = (^d) ^ ptype ^ flip_par;
      nb++;
    end
    nb += stop2 ? 2 : 1;
    if (push) exp_q.push_back({d, pen & flip_par, 1'b0, 1'b0});
    e0 = cyc + 1;
    for (int t = 0; t < nb * OS + OS; t++) begin
      if (t < nb * OS) rx = fb[t / OS] ^ (t == spike);
      else             rx = 1'b1;
      tick(1);
    end
  endtask

  // Monitor: compare every handed-over frame against the queue
  always @(negedge clk_16bd) begin
    if (!rst) begin
      if (rx_valid && !prev_valid) valid_cyc = cyc;
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [EW-1:0] exp;
          exp = exp_q.pop_front();
          check_eq("frame", 32'({rx_data, parity_err, frame_err, break_det}), 32'(exp));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    clr_overrun = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    tick(4);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(8);

    // 8N1 0xA5 with latency measurement
    valid_cyc = 0;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, -1);
    check_eq("latency_8n1", 32'(valid_cyc - e0), 32'd156);
    check_eq("valid_one_cycle", 32'(rx_valid), 32'd0);

    // 9E2: correct parity, then flipped parity
    send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, -1);
    send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, -1);
    // Odd parity, frame_length 0 and 15 both mean 9 bits
    send_frame(9'h0F0, 9, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, -1);
    send_frame(9'h13D, 9, 1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, -1);
    // Short frame: upper data bits must read 0
    send_frame(9'h015, 5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, -1);

    // Glitch: 4 ticks low is a false start
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check_eq("glitch_busy_set", 32'(busy), 32'd1);
    tick(OS);
    check_eq("glitch_busy_clear", 32'(busy), 32'd0);

    // Noise spike at a single centre sample of data bit 3
    send_frame(9'h000, 8, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, OS * 4 + OS / 2 + 1);

    // Random formats
    for (int k = 0; k < 4; k++) begin
      int nb;
      nb = $urandom_range(1, DATA_W);
      send_frame(9'($urandom_range(0, 511)), nb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(nb),
                 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    // Break: 20 bit times low gives exactly one flagged frame
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    exp_q.push_back({9'h000, 1'b0, 1'b1, 1'b1});
    rx = 1'b0;
    tick(20 * OS - 20);
    check_eq("break_busy_held", 32'(busy), 32'd1);
    tick(20);
    rx = 1'b1;
    tick(8);
    check_eq("break_busy_release", 32'(busy), 32'd0);
    tick(3 * OS);

    // Overrun: second frame is dropped while the first is held
    rx_ready = 1'b0;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, -1);
    check_eq("ovr_valid_first", 32'(rx_valid), 32'd1);
    check_eq("ovr_no_flag_yet", 32'(overrun), 32'd0);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, -1);
    check_eq("ovr_data_held", 32'(rx_data), 32'h011);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check_eq("ovr_valid_drop", 32'(rx_valid), 32'd0);
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check_eq("ovr_cleared", 32'(overrun), 32'd0);

    rx_ready = 1'b1;
    tick(4);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the team's UART frame processor. It receives one asynchronous serial line and uses OVERSAMPLE clock ticks per bit with 3-sample majority voting. Frame format is set at run time: 1..DATA_W data bits, optional even/odd parity, 1 or 2 stop bits. It delivers each frame with per-frame error flags through a valid/ready holding register that feeds the VGA command decoder.

Parameters:
DATA_W, 9, maximum data bits per frame; rx_data width.
OVERSAMPLE, 16, clk_16bd ticks per bit; even, >= 4.
FL_W, $clog2(DATA_W+1), width of frame_length (derived; do not override).

Ports:
clk_16bd  in  1  oversampling clock; only clock in the block.
rst  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial input; idles high.
parity_en  in  1  1 = parity bit present.
parity_type  in  1  0 = even, 1 = odd.
stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
frame_length  in  FL_W  data bits per frame; 0 or >DATA_W is treated as DATA_W.
rx_data  out  DATA_W  received data, LSB first into bit 0; unused upper bits are 0.
rx_valid  out  1  holding register full.
rx_ready  in  1  consumer accepts when rx_valid && rx_ready.
parity_err  out  1  parity mismatch; qualified by rx_valid.
frame_err  out  1  a stop bit sampled 0; qualified by rx_valid.
break_det  out  1  all data bits, the parity bit (if enabled) and the first stop bit are 0; qualified by rx_valid.
overrun  out  1  sticky: a frame completed while the holding register was full.
clr_overrun  in  1  clears overrun.
busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except rx_data = 0; synchroniser flops = 1; state IDLE; sample counter 0. A reset mid-frame aborts the frame with no output.
- rx passes through a 2-flop synchroniser to give rx_s (2 cycles of latency).
- Sample counter runs 0..OVERSAMPLE-1 and wraps. MID = OVERSAMPLE/2. Each bit value is the majority of rx_s at counts MID-1, MID and MID+1, decided at count MID+1.
- Configuration inputs are latched in IDLE on start detection and are ignored for the rest of the frame.
- IDLE: when rx_s = 0, counter <= 0 and state <= START.
- START: if the voted bit = 1 (false start), return to IDLE with no output. Otherwise go to DATA at count OVERSAMPLE-1.
- DATA: the voted bit is written to rx_data[idx], where idx runs 0..len-1. After the last bit, go to PARITY if parity_en, else STOP, at count OVERSAMPLE-1.
- PARITY: parity_err = (XOR of data bits ^ parity bit) != parity_type.
- STOP: each stop bit is voted; any 0 sets frame_err. On the decision of the final stop bit (count MID+1), the frame is delivered. The next state is then:
  - IDLE, if the stop bit was 1;
  - WAIT_HIGH, if it was 0. WAIT_HIGH holds until rx_s = 1, then goes to IDLE. This prevents a break from retriggering.
- Delivery, registered on the edge after the decision:
  - If the holding register is empty, or rx_valid && rx_ready in the same cycle, load rx_data and the flags and set rx_valid.
  - Otherwise discard the frame and set overrun.
- rx_valid and the flags hold stable until accepted. Acceptance clears rx_valid on the next edge unless a new frame loads in that same cycle.
- clr_overrun clears overrun; a new overrun in the same cycle wins (overrun stays 1).
- Latency: 8N1 at OVERSAMPLE=16. If edge E0 is the first edge sampling rx = 0, rx_valid is 1 after edge E0+156.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH); PARITY_EVEN = 0 and PARITY_ODD = 1 constants; STOP_1 and STOP_2 constants.
- Sub-module uart_rx_sampler: synchroniser, sample counter with restart, 3-sample majority vote. Outputs rx_s, bit_value, bit_decide (count MID+1) and bit_end (count OVERSAMPLE-1).

Test Plan:
- 8N1, rx_ready = 1, send 0xA5 → rx_valid for 1 cycle after E0+156, rx_data = 0x0A5, all flags 0.
- 9 bits, even parity, 2 stop bits, send 0x1C3 with a correct parity bit (1) → rx_data = 0x1C3, parity_err = 0. Repeat with the parity bit flipped → parity_err = 1 and the data is still delivered.
- 8N1 glitch: rx low for only 4 ticks → no rx_valid, busy returns to 0 within 1 bit time.
- 8N1 with a noise spike: a 1-tick spike at count MID inside data bit 3 of 0x00 → rx_data = 0x00 (majority vote rejects it).
- Break: rx held low for 20 bit times → exactly one frame with rx_data = 0, frame_err = 1, break_det = 1. busy stays 1 until rx returns high, and no second frame is delivered.
- Overrun: rx_ready = 0, send 0x11 then 0x22 → rx_data stays 0x11 and overrun = 1. Then pulse rx_ready → rx_valid drops. Then pulse clr_overrun → overrun = 0.
